lcd_bus_decoder: RTL and testbench
==================================

LCD_BUS_DECODER -- requirements
Module: lcd_bus_decoder

Interface
REQ-001 SHALL have parameter BUSY_LONG, default 76000, busy cycles after clear/home (1.52 ms at 50 MHz).
REQ-002 SHALL have parameter BUSY_SHORT, default 1850, busy cycles after any other accepted write (37 us at 50 MHz).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk, rst_n.
REQ-004 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports LCD_E, LCD_RS, LCD_RW, LCD_ON  input  1 each  character-LCD bus strobe, register select, read/write, power.
REQ-007 SHALL have port LCD_DATA  input  8  character-LCD bus data.
REQ-008 SHALL have port char_valid  output  1  one-cycle pulse per DDRAM data write.
REQ-009 SHALL have ports char_data  output  8, char_row  output  1, char_col  output  6  written character and its DDRAM position.
REQ-010 SHALL have ports cg_valid  output  1, cg_addr  output  6, cg_data  output  5  one-cycle pulse per CGRAM data write.
REQ-011 SHALL have ports disp_on, cursor_on, blink_on, entry_inc  output  1 each  current display-control and entry-mode state.
REQ-012 SHALL have ports busy  output  1  and  proto_err  output  1  (one-cycle pulse: write while busy).

Function
REQ-013 SHALL pass LCD_E, LCD_RS, LCD_RW, LCD_DATA through a common 2-flop synchronizer plus one delay flop on E; strobe = E falling edge (stage-3 high, stage-2 low).
REQ-014 SHALL ignore strobes while synchronized LCD_ON is low or LCD_RW is high (reads: no output, no state change, no busy).
REQ-015 SHALL register all decode results; output pulses SHALL appear exactly 3 clk cycles after the first clk edge sampling LCD_E low, for one cycle.
REQ-016 SHALL hold a 7-bit DDRAM address ADDR; legal ranges 0x00-0x27 (row 0) and 0x40-0x67 (row 1); char_row = ADDR[6], char_col = ADDR[5:0] at time of write.
REQ-017 SHALL decode RS=0 writes by highest set bit: 0x01 clear (ADDR=0, entry_inc=1), 0x02-0x03 home (ADDR=0), 0x04-0x07 entry mode (entry_inc=D[1]), 0x08-0x0F display control (disp_on=D[2], cursor_on=D[1], blink_on=D[0]), 0x10-0x1F cursor/shift (if D[3]=0 move ADDR by D[2]?+1:-1; if D[3]=1 no ADDR change), 0x20-0x3F function set (no state change), 0x40-0x7F set CGRAM (mode=CG, cg pointer=D[5:0]), 0x80-0xFF set DDRAM (mode=DD, ADDR=D[6:0], values 0x28-0x3F mapped to 0x00, 0x68-0x7F to 0x40).
REQ-018 SHALL, on RS=1 write in DD mode, pulse char_valid with char_data=D, then step ADDR per entry_inc.
REQ-019 SHALL, on RS=1 write in CG mode, pulse cg_valid with cg_addr=pointer, cg_data=D[4:0], then step pointer per entry_inc, wrapping mod 64.
REQ-020 SHALL wrap ADDR stepping: increment 0x27->0x40, 0x67->0x00; decrement 0x00->0x67, 0x40->0x27.
REQ-021 SHALL load a busy counter on every accepted write: BUSY_LONG for clear/home, else BUSY_SHORT; busy=1 while counter nonzero.
REQ-022 SHALL, on a write while busy, still decode it, pulse proto_err, and reload the counter from that write.
REQ-023 SHALL process at most one strobe per E falling edge; E high for any duration produces no action.

Reset
REQ-024 SHALL on rst_n low asynchronously clear synchronizers, ADDR=0, cg pointer=0, mode=DD, disp_on=0, cursor_on=0, blink_on=0, entry_inc=1, busy counter=0, all pulses and data outputs 0.
REQ-025 SHALL, if reset asserts mid-strobe, produce no pulse for that strobe after release unless a new E falling edge occurs.

Verification
REQ-026 SHALL cover: reset, then cmd 0x0C -> disp_on=1, cursor_on=0, blink_on=0; busy high exactly 1850 cycles.
REQ-027 SHALL cover: cmd 0x80, data 0x41,0x42 -> char_valid twice, (row0,col0,0x41) then (row0,col1,0x42).
REQ-028 SHALL cover: cmd 0xA7, data 0x58 twice -> positions (0,0x27) then (1,0x00); cmd 0x04 then data at ADDR 0x00 -> next ADDR 0x67.
REQ-029 SHALL cover: cmd 0x01 then data write 100 cycles later -> proto_err pulse, char at (0,0), busy reloaded to 1850.
REQ-030 SHALL cover: cmd 0x48, data 0x1F -> cg_valid, cg_addr=0x08, cg_data=0x1F; LCD_RW=1 or LCD_ON=0 strobes -> no pulses, no state change.

Source files
------------

// File: rtl/lcd_bus_decoder.sv
// Passive decoder for an HD44780-style character-LCD write bus.
// It watches the controller's bus and reports the characters and CGRAM rows
// written, the display/entry state, and the busy window after each write.
module lcd_bus_decoder #(
  parameter int unsigned BUSY_LONG  = 76000,
  parameter int unsigned BUSY_SHORT = 1850
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_ON,
  input  logic [7:0] LCD_DATA,
  output logic       char_valid,
  output logic [7:0] char_data,
  output logic       char_row,
  output logic [5:0] char_col,
  output logic       cg_valid,
  output logic [5:0] cg_addr,
  output logic [4:0] cg_data,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       busy,
  output logic       proto_err
);

  localparam int unsigned BUSY_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
  localparam int unsigned CNT_W    = $clog2(BUSY_MAX + 1);
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned PTR_W    = 6;

  localparam logic [ADDR_W-1:0] ROW0_LAST  = 7'h27;
  localparam logic [ADDR_W-1:0] ROW1_FIRST = 7'h40;
  localparam logic [ADDR_W-1:0] ROW1_LAST  = 7'h67;

  // Step a DDRAM address, wrapping between the two 40-column rows.
  function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a, input logic up);
    logic [ADDR_W-1:0] r;
    if (up) begin
      if (a == ROW0_LAST)      r = ROW1_FIRST;
      else if (a == ROW1_LAST) r = '0;
      else                     r = a + ADDR_W'(1);
    end else begin
      if (a == '0)              r = ROW1_LAST;
      else if (a == ROW1_FIRST) r = ROW0_LAST;
      else                      r = a - ADDR_W'(1);
    end
    return r;
  endfunction

  // Fold out-of-row columns (0x28-0x3F within a row) back to column 0.
  function automatic logic [ADDR_W-1:0] ddram_map(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    if (v[5:0] > 6'h27) r = {v[6], 6'h00};
    else                r = v;
    return r;
  endfunction

  // Synchronizer stages (common to all bus lines) plus the E delay flop.
  logic       e_s1, e_s2, e_s3;
  logic       rs_s1, rs_s2, rw_s1, rw_s2, on_s1, on_s2;
  logic [7:0] data_s1, data_s2;

  // Captured write (one cycle after the falling edge is seen).
  logic       stb_q;
  logic       stb_rs_q;
  logic [7:0] stb_data_q;

  // Decoder state.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              cg_mode_q, cg_mode_d;
  logic              disp_d, cursor_d, blink_d, inc_d;
  logic              long_d, char_v_d, cg_v_d;
  logic [CNT_W-1:0]  cnt_q, load_d;
  logic              strobe_c;

  assign strobe_c = e_s3 & ~e_s2 & on_s2 & ~rw_s2;

  // Bring the asynchronous bus into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_s1 <= 1'b0; e_s2 <= 1'b0; e_s3 <= 1'b0;
      rs_s1 <= 1'b0; rs_s2 <= 1'b0;
      rw_s1 <= 1'b0; rw_s2 <= 1'b0;
      on_s1 <= 1'b0; on_s2 <= 1'b0;
      data_s1 <= '0; data_s2 <= '0;
    end else begin
      e_s1 <= LCD_E;    e_s2 <= e_s1;   e_s3 <= e_s2;
      rs_s1 <= LCD_RS;  rs_s2 <= rs_s1;
      rw_s1 <= LCD_RW;  rw_s2 <= rw_s1;
      on_s1 <= LCD_ON;  on_s2 <= on_s1;
      data_s1 <= LCD_DATA; data_s2 <= data_s1;
    end
  end

  // Latch an accepted write strobe together with its RS and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q      <= 1'b0;
      stb_rs_q   <= 1'b0;
      stb_data_q <= '0;
    end else begin
      stb_q <= strobe_c;
      if (strobe_c) begin
        stb_rs_q   <= rs_s2;
        stb_data_q <= data_s2;
      end
    end
  end

  // Next-state decode of the captured write.
  always_comb begin
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    cg_mode_d = cg_mode_q;
    disp_d    = disp_on;
    cursor_d  = cursor_on;
    blink_d   = blink_on;
    inc_d     = entry_inc;
    long_d    = 1'b0;
    char_v_d  = 1'b0;
    cg_v_d    = 1'b0;
    if (stb_q) begin
      if (stb_rs_q) begin
        if (cg_mode_q) begin
          cg_v_d = 1'b1;
          ptr_d  = entry_inc ? ptr_q + PTR_W'(1) : ptr_q - PTR_W'(1);
        end else begin
          char_v_d = 1'b1;
          addr_d   = addr_step(addr_q, entry_inc);
        end
      end else begin
        casez (stb_data_q)
          8'b1???????: begin
            cg_mode_d = 1'b0;
            addr_d    = ddram_map(stb_data_q[6:0]);
          end
          8'b01??????: begin
            cg_mode_d = 1'b1;
            ptr_d     = stb_data_q[5:0];
          end
          8'b001?????: begin
            // function set: bus width / lines / font, no tracked state
          end
          8'b0001????: begin
            if (!stb_data_q[3]) addr_d = addr_step(addr_q, stb_data_q[2]);
          end
          8'b00001???: begin
            disp_d   = stb_data_q[2];
            cursor_d = stb_data_q[1];
            blink_d  = stb_data_q[0];
          end
          8'b000001??: inc_d = stb_data_q[1];
          8'b0000001?: begin
            addr_d = '0;
            long_d = 1'b1;
          end
          8'b00000001: begin
            addr_d = '0;
            inc_d  = 1'b1;
            long_d = 1'b1;
          end
          default: begin
            // 0x00 is not a command; only the busy time applies
          end
        endcase
      end
    end
    load_d = long_d ? CNT_W'(BUSY_LONG) : CNT_W'(BUSY_SHORT);
  end

  // Decoder state, registered outputs and busy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      ptr_q      <= '0;
      cg_mode_q  <= 1'b0;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      entry_inc  <= 1'b1;
      char_valid <= 1'b0;
      char_data  <= '0;
      char_row   <= 1'b0;
      char_col   <= '0;
      cg_valid   <= 1'b0;
      cg_addr    <= '0;
      cg_data    <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      ptr_q      <= ptr_d;
      cg_mode_q  <= cg_mode_d;
      disp_on    <= disp_d;
      cursor_on  <= cursor_d;
      blink_on   <= blink_d;
      entry_inc  <= inc_d;
      char_valid <= char_v_d;
      cg_valid   <= cg_v_d;
      if (char_v_d) begin
        char_data <= stb_data_q;
        char_row  <= addr_q[6];
        char_col  <= addr_q[5:0];
      end
      if (cg_v_d) begin
        cg_addr <= ptr_q;
        cg_data <= stb_data_q[4:0];
      end
      if (stb_q) begin
        proto_err <= (cnt_q != '0);
        cnt_q     <= load_d;
        busy      <= (load_d != '0);
      end else begin
        proto_err <= 1'b0;
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
          busy  <= (cnt_q != CNT_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Randomized scoreboard bench for lcd_bus_decoder with a row/column reference model.
module tb_lcd_bus_decoder;

  localparam int BL = 76000;
  localparam int BS = 1850;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_on = 1'b1;
  logic [7:0] lcd_data = 8'h00;
  logic       char_valid, char_row, cg_valid;
  logic [7:0] char_data;
  logic [5:0] char_col, cg_addr;
  logic [4:0] cg_data;
  logic       disp_on, cursor_on, blink_on, entry_inc, busy, proto_err;

  lcd_bus_decoder #(.BUSY_LONG(BL), .BUSY_SHORT(BS)) dut (
    .clk(clk), .rst_n(rst_n),
    .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_ON(lcd_on), .LCD_DATA(lcd_data),
    .char_valid(char_valid), .char_data(char_data), .char_row(char_row), .char_col(char_col),
    .cg_valid(cg_valid), .cg_addr(cg_addr), .cg_data(cg_data),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         chv;
    logic [7:0] chd;
    bit         row;
    logic [5:0] col;
    bit         cgv;
    logic [5:0] cga;
    logic [4:0] cgd;
    bit         perr;
  } ev_t;

  ev_t sb[$];

  int checks = 0;
  int failures = 0;

  // reference model: cursor as (row, column 0..39)
  int m_row, m_col, m_ptr, m_busy_end;
  bit m_cg, m_disp, m_cur, m_blink, m_inc;

  // state expected right after the next decode
  int p_cyc, p_end;
  bit p_done, p_disp, p_cur, p_blink, p_inc;
  int cur_end = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_pend(input int at);
    p_cyc = at; p_done = 0; p_end = m_busy_end;
    p_disp = m_disp; p_cur = m_cur; p_blink = m_blink; p_inc = m_inc;
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_ptr = 0; m_cg = 0;
    m_disp = 0; m_cur = 0; m_blink = 0; m_inc = 1; m_busy_end = 0;
    sb.delete();
    set_pend(0);
  endtask

  task automatic cursor_move(input bit up);
    if (up) begin
      m_col++;
      if (m_col == 40) begin m_col = 0; m_row = 1 - m_row; end
    end else if (m_col == 0) begin
      m_col = 39; m_row = 1 - m_row;
    end else begin
      m_col--;
    end
  endtask

  task automatic model_apply(input bit rs, input logic [7:0] d, input bit rw, input bit on, input int dc);
    ev_t e;
    int  v;
    bit  lng;
    lng = 0;
    if (!on || rw) begin
      set_pend(dc);
      return;
    end
    e.cyc = dc; e.chv = 0; e.chd = 0; e.row = 0; e.col = 0;
    e.cgv = 0; e.cga = 0; e.cgd = 0;
    e.perr = (dc < m_busy_end);
    if (rs) begin
      if (m_cg) begin
        e.cgv = 1; e.cga = 6'(m_ptr); e.cgd = d[4:0];
        m_ptr = (m_ptr + (m_inc ? 1 : 63)) % 64;
      end else begin
        e.chv = 1; e.chd = d; e.row = (m_row == 1); e.col = 6'(m_row * 0 + m_col);
        cursor_move(m_inc);
      end
    end else if (d >= 128) begin
      m_cg = 0; v = d % 128; m_row = v / 64; m_col = v % 64;
      if (m_col >= 40) m_col = 0;
    end else if (d >= 64) begin
      m_cg = 1; m_ptr = d % 64;
    end else if (d >= 32) begin
      m_cg = m_cg;
    end else if (d >= 16) begin
      if (!d[3]) cursor_move(d[2]);
    end else if (d >= 8) begin
      m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
    end else if (d >= 4) begin
      m_inc = d[1];
    end else if (d >= 2) begin
      m_row = 0; m_col = 0; lng = 1;
    end else if (d == 1) begin
      m_row = 0; m_col = 0; m_inc = 1; lng = 1;
    end
    m_busy_end = dc + (lng ? BL : BS);
    if (e.chv || e.cgv || e.perr) sb.push_back(e);
    set_pend(dc);
  endtask

  // One bus write cycle: E high for 3 cycles, then low for 'hold' cycles.
  task automatic bus_write(input bit rs, input logic [7:0] d, input bit rw, input bit on, input int hold);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_on = on; lcd_data = d; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    model_apply(rs, d, rw, on, cyc + 4);
    repeat (hold) @(negedge clk);
    lcd_on = 1'b1; lcd_rw = 1'b0;
  endtask

  // Monitor: pulses against the scoreboard, state after each decode, busy edges.
  initial begin
    bit prev_busy, prev_exp, exp_busy;
    ev_t e;
    prev_busy = 0; prev_exp = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        prev_busy = 0; prev_exp = 0;
      end else begin
        if (!p_done && cyc >= p_cyc) begin
          cur_end = p_end; p_done = 1;
          chk("disp_on", disp_on, p_disp);
          chk("cursor_on", cursor_on, p_cur);
          chk("blink_on", blink_on, p_blink);
          chk("entry_inc", entry_inc, p_inc);
          chk("busy_after_decode", busy, cyc < cur_end);
        end
        exp_busy = (cyc < cur_end);
        if (busy != prev_busy || exp_busy != prev_exp) chk("busy_edge", busy, exp_busy);
        prev_busy = busy; prev_exp = exp_busy;
        if (char_valid || cg_valid || proto_err) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_pulse cyc=%0d char_valid=%0b cg_valid=%0b proto_err=%0b required none",
                     cyc, char_valid, cg_valid, proto_err);
          end else begin
            e = sb.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("char_valid", char_valid, e.chv);
            chk("cg_valid", cg_valid, e.cgv);
            chk("proto_err", proto_err, e.perr);
            if (e.chv) begin
              chk("char_data", char_data, e.chd);
              chk("char_row", char_row, e.row);
              chk("char_col", char_col, e.col);
            end
            if (e.cgv) begin
              chk("cg_addr", cg_addr, e.cga);
              chk("cg_data", cg_data, e.cgd);
            end
          end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          checks++; failures++;
          $display("FAIL missing_pulse cyc=%0d got none required pulse at cyc=%0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int r;
    bit rs, rw, on;
    logic [7:0] d;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // display control, then let the short busy window expire
    bus_write(0, 8'h0C, 0, 1, 1900);
    // character writes from home
    bus_write(0, 8'h80, 0, 1, 6);
    bus_write(1, 8'h41, 0, 1, 6);
    bus_write(1, 8'h42, 0, 1, 6);
    // row-end wrap, then backwards wrap from 0x00
    bus_write(0, 8'hA7, 0, 1, 6);
    bus_write(1, 8'h58, 0, 1, 6);
    bus_write(1, 8'h58, 0, 1, 6);
    bus_write(0, 8'h04, 0, 1, 6);
    bus_write(0, 8'h80, 0, 1, 6);
    bus_write(1, 8'h61, 0, 1, 6);
    bus_write(1, 8'h62, 0, 1, 6);
    // clear, then a write inside the long busy window
    bus_write(0, 8'h01, 0, 1, 100);
    bus_write(1, 8'h43, 0, 1, 1900);
    // CGRAM write, ignored read / power-off strobes, CGRAM again
    bus_write(0, 8'h48, 0, 1, 6);
    bus_write(1, 8'h1F, 0, 1, 6);
    bus_write(1, 8'h33, 1, 1, 6);
    bus_write(0, 8'h80, 0, 0, 6);
    bus_write(1, 8'h0A, 0, 1, 6);

    // reset in the middle of a strobe
    bus_write(0, 8'h0F, 0, 1, 6);
    @(negedge clk);
    lcd_rs = 1'b1; lcd_data = 8'h55; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    bus_write(1, 8'h30, 0, 1, 6);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      rs = 0; rw = 0; on = 1; d = 8'($urandom_range(0, 255));
      if (r < 40)      rs = 1;
      else if (r < 50) d = 8'h80 | 8'($urandom_range(0, 127));
      else if (r < 55) d = 8'h40 | 8'($urandom_range(0, 63));
      else if (r < 62) d = 8'h04 | 8'($urandom_range(0, 3));
      else if (r < 70) d = 8'h08 | 8'($urandom_range(0, 7));
      else if (r < 80) d = 8'h10 | 8'($urandom_range(0, 15));
      else if (r < 84) d = 8'h20 | 8'($urandom_range(0, 31));
      else if (r < 86) d = 8'($urandom_range(1, 3));
      else if (r < 93) begin rw = 1; rs = 1'($urandom_range(0, 1)); end
      else             on = 0;
      bus_write(rs, d, rw, on, ($urandom_range(0, 15) == 0) ? 1900 : $urandom_range(5, 12));
    end

    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
